// File: rtl/vector_sum_ctrl_if.sv
// rtl/vector_sum_ctrl_if.sv - input vector / output sum handshake bundle for vector_sum_ctrl
interface vector_sum_ctrl_if #(
    parameter int DIM = 2,
    parameter int W_u = 32
);
    localparam int SW = W_u + $clog2(DIM);

    logic [DIM*W_u-1:0] in_vec;
    logic               in_valid;
    logic               in_ready;
    logic [SW-1:0]      out_sum;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_sum, out_valid
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_sum, out_valid
    );
endinterface

// File: rtl/vector_sum_ctrl.sv
// rtl/vector_sum_ctrl.sv - credit-controlled vector summer with in-order result FIFO
// Optional pop counter output sum_count_o enabled by macro VSUM_CTRL_STATS_EN.
module vectorSum #(
    parameter int DIM = 2,
    parameter int W_u = 32
) (
    input  logic                        clk_i,
    input  logic [DIM*W_u-1:0]          u_i,
    output logic [W_u+$clog2(DIM)-1:0]  sum_o
);
    localparam int SW = W_u + $clog2(DIM);

    logic [SW-1:0] sum_d;
    logic [SW-1:0] pipe_q [DIM];

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < DIM; i++) begin
            sum_d = sum_d + SW'(u_i[W_u*i +: W_u]);
        end
    end

    // Retimable delay line: the sum leaves exactly DIM edges after capture.
    always_ff @(posedge clk_i) begin
        pipe_q[0] <= sum_d;
        for (int s = 1; s < DIM; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign sum_o = pipe_q[DIM-1];
endmodule

module vector_sum_ctrl #(
    parameter int DIM       = 2,
    parameter int W_u       = 32,
    parameter int OUT_DEPTH = 8
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    vector_sum_ctrl_if.slave    bus,
`ifdef VSUM_CTRL_STATS_EN
    output logic [15:0]         sum_count_o,
`endif
    output logic                busy_o
);
    localparam int SW = W_u + $clog2(DIM);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int OW = $clog2(OUT_DEPTH + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic               accept;
    logic               pop;
    logic [DIM*W_u-1:0] dp_u;
    logic [SW-1:0]      dp_sum;

    logic [DIM-1:0]     vld_q, vld_d;
    logic               wr_vld_q;
    logic [SW-1:0]      wr_sum_q;
    logic [SW-1:0]      fifo_mem_q [OUT_DEPTH];
    logic [AW:0]        wptr_q, rptr_q;
    logic [OW-1:0]      occ_q, occ_d;
    logic [0:0]         state_q, state_d;

    assign accept = bus.in_valid & bus.in_ready;
    assign pop    = bus.out_valid & bus.out_ready;
    assign dp_u   = accept ? bus.in_vec : '0;

    vectorSum #(.DIM(DIM), .W_u(W_u)) u_vector_sum (
        .clk_i (clk_i),
        .u_i   (dp_u),
        .sum_o (dp_sum)
    );

    assign vld_d = (vld_q << 1) | DIM'(accept);

    // Occupancy counts every accepted vector until it is popped, so FIFO room is reserved up front.
    always_comb begin
        occ_d = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !accept) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_ACTIVE;
        end else if (occ_d == '0) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            vld_q    <= '0;
            wr_vld_q <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            occ_q    <= '0;
            state_q  <= ST_IDLE;
        end else begin
            vld_q    <= vld_d;
            wr_vld_q <= vld_q[DIM-1];
            occ_q    <= occ_d;
            state_q  <= state_d;
            if (wr_vld_q) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Datapath storage is never reset; only the tracked valid bits decide what gets committed.
    always_ff @(posedge clk_i) begin
        wr_sum_q <= dp_sum;
        if (wr_vld_q) begin
            fifo_mem_q[wptr_q[AW-1:0]] <= wr_sum_q;
        end
    end

    assign bus.in_ready  = (occ_q < OW'(OUT_DEPTH));
    assign bus.out_valid = (wptr_q != rptr_q);
    assign bus.out_sum   = fifo_mem_q[rptr_q[AW-1:0]];
    assign busy_o        = (state_q == ST_ACTIVE);

`ifdef VSUM_CTRL_STATS_EN
    logic [15:0] sum_count_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sum_count_q <= '0;
        end else if (pop && (sum_count_q != 16'hFFFF)) begin
            sum_count_q <= sum_count_q + 16'd1;
        end
    end

    assign sum_count_o = sum_count_q;
`endif
endmodule

// File: tb/tb_vector_sum_ctrl.sv
// tb/tb_vector_sum_ctrl.sv - scoreboard bench for vector_sum_ctrl (DIM=4, W_u=8, OUT_DEPTH=8)
module tb_vector_sum_ctrl;
    localparam int DIM       = 4;
    localparam int W_u       = 8;
    localparam int OUT_DEPTH = 8;
    localparam int SW        = 10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy;
`ifdef VSUM_CTRL_STATS_EN
    logic [15:0] sum_count;
`endif

    vector_sum_ctrl_if #(.DIM(DIM), .W_u(W_u)) bus ();

    vector_sum_ctrl #(.DIM(DIM), .W_u(W_u), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .bus         (bus),
`ifdef VSUM_CTRL_STATS_EN
        .sum_count_o (sum_count),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned sum;
        int          acc_edge;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int pops = 0;
    int pops_since_rst = 0;
    int first_pop = -1;
    int last_pop = -1;
    logic stall_prev = 1'b0;
    logic [SW-1:0] sum_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int unsigned model_sum(input logic [31:0] v);
        int unsigned s = 0;
        for (int i = 0; i < DIM; i++) s += int'(v[8*i +: 8]);
        return s;
    endfunction

    // Monitor: a pop happens on the next rising edge when out_valid && out_ready at the falling edge.
    always @(negedge clk) begin
        if (!resetn) begin
            stall_prev = 1'b0;
            pops_since_rst = 0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", bus.out_valid, 1);
                if (bus.out_valid) check("stall_hold_sum", bus.out_sum, sum_prev);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sum: got %0d expected none (cycle %0d)", bus.out_sum, cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("sum", bus.out_sum, e.sum);
                    check("latency_min", (cyc >= e.acc_edge + DIM + 1), 1);
                end
                pops++;
                pops_since_rst++;
                if (first_pop < 0) first_pop = cyc + 1;
                last_pop = cyc + 1;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            sum_prev = bus.out_sum;
        end
    end

    task automatic step(input logic v, input logic [31:0] vec, input logic ordy, output logic acc);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.in_vec = vec;
        bus.out_ready = ordy;
        @(negedge clk);
        acc = v && bus.in_ready;
        if (acc) sbq.push_back('{model_sum(vec), cyc + 1});
    endtask

    task automatic drain();
        int n = 0;
        logic a;
        while ((sbq.size() != 0 || bus.out_valid) && n < 60) begin
            step(1'b0, 32'h0, 1'b1, a);
            n++;
        end
        check("drain_done", sbq.size(), 0);
    endtask

    initial begin
        logic a;
        int cnt;
        int bad_vis;
        logic [31:0] v;

        bus.in_valid = 1'b0;
        bus.in_vec = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", busy, 0);

        // Single vector {1,2,3,4}: visible only after edge k+5, then idle after the pop.
        step(1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, a);
        check("single_accept", a, 1);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 32'h0, 1'b1, a);
            check("single_latency", bus.out_valid, (i == 6));
            if (i == 3) check("single_busy", busy, 1);
        end
        step(1'b0, 32'h0, 1'b1, a);
        check("single_idle_valid", bus.out_valid, 0);
        check("single_idle_busy", busy, 0);

        step(1'b1, 32'hFFFF_FFFF, 1'b1, a);
        drain();

        // 20 back-to-back with out_ready held high.
        first_pop = -1;
        cnt = pops;
        for (int i = 0; i < 20; i++) begin
            v = $urandom;
            step(1'b1, v, 1'b1, a);
            check("b2b_accept", a, 1);
        end
        drain();
        check("b2b_count", pops - cnt, 20);
        check("b2b_rate", last_pop - first_pop, 19);

        // Full backpressure: exactly OUT_DEPTH accepted.
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            v = $urandom;
            step(1'b1, v, 1'b0, a);
            if (a) cnt++;
        end
        check("bp_accepted", cnt, OUT_DEPTH);
        check("bp_in_ready_low", bus.in_ready, 0);
        step(1'b0, 32'h0, 1'b1, a);
        check("bp_before_pop", bus.in_ready, 0);
        step(1'b0, 32'h0, 1'b1, a);
        check("bp_after_pop", bus.in_ready, 1);
        drain();

        // Mid-operation reset with 2 buffered and 3 in flight.
        for (int i = 0; i < 5; i++) begin
            v = $urandom;
            step(1'b1, v, 1'b0, a);
        end
        step(1'b0, 32'h0, 1'b0, a);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_in_ready", bus.in_ready, 1);
        check("mrst_busy", busy, 0);
        bad_vis = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b1, a);
            if (bus.out_valid) bad_vis++;
        end
        check("mrst_no_ghost", bad_vis, 0);
        step(1'b1, {8'd5, 8'd5, 8'd5, 8'd5}, 1'b1, a);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            v = $urandom;
            step(($urandom_range(0, 2) != 0), v, ($urandom_range(0, 3) != 0), a);
        end
        drain();
        step(1'b0, 32'h0, 1'b1, a);
        check("final_busy", busy, 0);

`ifdef VSUM_CTRL_STATS_EN
        check("sum_count", sum_count, pops_since_rst);
        force dut.sum_count_q = 16'hFFFF;
        @(posedge clk);
        release dut.sum_count_q;
        step(1'b1, 32'h0101_0101, 1'b1, a);
        drain();
        check("sum_count_sat", sum_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
